clk_param_monitor: RTL and testbench



---
 rtl/clk_param_monitor.sv | 128 ++++++++++++
 tb/tb_clk_param_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_param_monitor.sv
// rtl/clk_param_monitor.sv - clk_in synchroniser, edge strobes, period measurement and lock detect
`timescale 1ns/1ps
module clk_param_monitor #(
    parameter real FREQ_MHz    = 1.0,
    parameter int  TOLERANCE   = 1,
    parameter int  LOCK_COUNT  = 4,
    parameter int  SYNC_STAGES = 2,
    localparam int EXP = $rtoi(100.0 / FREQ_MHz),
    localparam int W   = $clog2(EXP + TOLERANCE + 1)
) (
    input  logic         clk_100,
    input  logic         rst,
    input  logic         clk_in,
    output logic         rise_strobe,
    output logic         fall_strobe,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0] C_MAX    = W'(EXP + TOLERANCE);
    localparam logic [W-1:0] C_MAX_M1 = W'(EXP + TOLERANCE - 1);
    localparam logic [W-1:0] C_LO     = W'((EXP > TOLERANCE) ? (EXP - TOLERANCE) : 0);
    localparam logic [GW-1:0] C_LAST  = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [W-1:0]           r_cnt;
    logic [W-1:0]           r_period;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_timeout;
    logic                   r_first_seen;
    logic [GW-1:0]          r_good;
    state_t                 r_state;

    logic                   w_rise;
    logic                   w_fall;
    logic [W-1:0]           w_meas;
    logic                   w_match;

    assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;
    // Count restarts at 0 on the strobe, so the period is one more than the count seen.
    assign w_meas  = r_cnt + W'(1);
    assign w_match = (w_meas >= C_LO) && (w_meas <= C_MAX);

    assign rise_strobe  = w_rise;
    assign fall_strobe  = w_fall;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

    // Bring clk_in into the clk_100 domain and keep the previous synchronised level for edge detection
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Period counter, timeout detection and lock state machine with registered outputs
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
            r_first_seen   <= 1'b0;
            r_good         <= '0;
            r_state        <= ST_IDLE;
        end else begin
            r_period_valid <= 1'b0;
            // Leaving LOCKED on a mismatch shows up on locked one cycle after period_valid.
            r_locked       <= (r_state == ST_LOCKED);
            if (w_rise) begin
                r_cnt     <= '0;
                r_timeout <= 1'b0;
                if (!r_first_seen) begin
                    // First edge after reset or timeout only arms the measurement.
                    r_first_seen <= 1'b1;
                    r_good       <= '0;
                    r_state      <= ST_MEASURE;
                end else begin
                    r_period       <= w_meas;
                    r_period_valid <= 1'b1;
                    if (w_match) begin
                        if (r_state != ST_LOCKED) begin
                            if (r_good == C_LAST) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_good <= r_good + GW'(1);
                            end
                        end
                    end else begin
                        r_good  <= '0;
                        r_state <= ST_MEASURE;
                    end
                end
            end else if (r_cnt == C_MAX_M1) begin
                // No edge within the widest accepted period: drop everything back to IDLE.
                r_cnt        <= C_MAX;
                r_timeout    <= 1'b1;
                r_first_seen <= 1'b0;
                r_good       <= '0;
                r_state      <= ST_IDLE;
                r_locked     <= 1'b0;
            end else if (r_cnt != C_MAX) begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_param_monitor.sv
// tb/tb_clk_param_monitor.sv - directed bench for clk_param_monitor
`timescale 1ns/1ps
module tb_clk_param_monitor;

    localparam int LOGN = 8192;

    logic       clk_100 = 1'b0;
    logic       rst;
    logic       clk_in;
    logic       rise_strobe;
    logic       fall_strobe;
    logic [6:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic lock_log [0:LOGN-1];
    logic to_log   [0:LOGN-1];
    int   rise_q[$];
    int   fall_q[$];
    int   pv_cyc[$];
    int   pv_val[$];
    int   pv_lock[$];

    clk_param_monitor dut (
        .clk_100      (clk_100),
        .rst          (rst),
        .clk_in       (clk_in),
        .rise_strobe  (rise_strobe),
        .fall_strobe  (fall_strobe),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    // Log outputs mid-cycle, indexed by the number of the preceding clk_100 edge
    always @(negedge clk_100) begin
        if (cyc < LOGN) begin
            lock_log[cyc] = locked;
            to_log[cyc]   = timeout;
        end
        if (rise_strobe) rise_q.push_back(cyc);
        if (fall_strobe) fall_q.push_back(cyc);
        if (period_valid) begin
            pv_cyc.push_back(cyc);
            pv_val.push_back(int'(period));
            pv_lock.push_back(int'(locked));
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        rise_q.delete();
        fall_q.delete();
        pv_cyc.delete();
        pv_val.delete();
        pv_lock.delete();
    endtask

    task automatic hold(input logic lvl, input int n);
        clk_in = lvl;
        repeat (n) @(negedge clk_100);
    endtask

    task automatic period_hl(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    function automatic int count_ones(input int from, input int to, input bit use_to);
        int n = 0;
        for (int i = from; i <= to; i++) begin
            if (i >= 0 && i < LOGN) begin
                if (use_to ? (to_log[i] === 1'b1) : (lock_log[i] === 1'b1)) n++;
            end
        end
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int r0;
        int t_start;
        rst    = 1'b1;
        clk_in = 1'b0;
        repeat (2) @(negedge clk_100);
        check_eq("rst_rise",   int'(rise_strobe),  0);
        check_eq("rst_fall",   int'(fall_strobe),  0);
        check_eq("rst_period", int'(period),       0);
        check_eq("rst_pv",     int'(period_valid), 0);
        check_eq("rst_locked", int'(locked),       0);
        check_eq("rst_to",     int'(timeout),      0);
        @(negedge clk_100);
        rst = 1'b0;
        while (cyc < 9) @(negedge clk_100);

        // Nominal 50/50 clock: rise driven before edge 10, five rises
        clear_q();
        repeat (5) period_hl(50, 50);
        #1;
        check_eq("p1_rise_count", rise_q.size(), 5);
        check_eq("p1_fall_count", fall_q.size(), 5);
        if (rise_q.size() > 0) check_eq("p1_first_rise_cyc", rise_q[0], 11);
        for (int i = 0; i < rise_q.size() && i < fall_q.size(); i++)
            check_eq("p1_fall_after_rise", fall_q[i] - rise_q[i], 50);
        check_eq("p1_pv_count", pv_val.size(), 4);
        if (pv_cyc.size() > 0) check_eq("p1_first_pv_cyc", pv_cyc[0], 112);
        foreach (pv_val[i]) check_eq("p1_period", pv_val[i], 100);
        if (pv_lock.size() == 4) begin
            check_eq("p1_lock_at_pv3", pv_lock[2], 0);
            check_eq("p1_lock_at_pv4", pv_lock[3], 1);
        end
        check_eq("p1_no_timeout", count_ones(0, cyc - 1, 1'b1), 0);

        // One short period (98) while locked, then four good periods
        clear_q();
        period_hl(49, 49);
        repeat (4) period_hl(50, 50);
        #1;
        check_eq("p2_pv_count", pv_val.size(), 5);
        if (pv_val.size() == 5) begin
            check_eq("p2_period0", pv_val[0], 100);
            check_eq("p2_lock0", pv_lock[0], 1);
            check_eq("p2_short_period", pv_val[1], 98);
            check_eq("p2_lock_at_short_pv", int'(lock_log[pv_cyc[1]]), 1);
            check_eq("p2_lock_after_short_pv", int'(lock_log[pv_cyc[1] + 1]), 0);
            check_eq("p2_lock_at_3rd_good", pv_lock[4], 0);
        end

        // Boundary periods 99 and 101 interleaved with 100
        clear_q();
        t_start = cyc;
        period_hl(50, 49);
        period_hl(50, 50);
        period_hl(50, 51);
        period_hl(50, 50);
        period_hl(50, 49);
        period_hl(51, 50);
        #1;
        check_eq("p3_pv_count", pv_val.size(), 6);
        if (pv_val.size() == 6) begin
            check_eq("p3_relock", pv_lock[0], 1);
            check_eq("p3_period0", pv_val[0], 100);
            check_eq("p3_period1", pv_val[1], 99);
            check_eq("p3_period2", pv_val[2], 100);
            check_eq("p3_period3", pv_val[3], 101);
            check_eq("p3_period4", pv_val[4], 100);
            check_eq("p3_period5", pv_val[5], 99);
            check_eq("p3_lock_drops", (cyc - pv_cyc[0]) - count_ones(pv_cyc[0], cyc - 1, 1'b0), 0);
        end
        check_eq("p3_no_timeout", count_ones(t_start, cyc - 1, 1'b1), 0);

        // Hold clk_in low after lock until timeout
        clear_q();
        hold(1'b1, 50);
        hold(1'b0, 202);
        #1;
        check_eq("p4_pv_count", pv_val.size(), 1);
        if (pv_val.size() == 1) begin
            check_eq("p4_period_101", pv_val[0], 101);
            check_eq("p4_lock_101", pv_lock[0], 1);
        end
        if (rise_q.size() == 1) begin
            a = rise_q[0];
            check_eq("p4_to_before", int'(to_log[a + 101]), 0);
            check_eq("p4_to_at",     int'(to_log[a + 102]), 1);
            check_eq("p4_lock_before", int'(lock_log[a + 101]), 1);
            check_eq("p4_lock_at",     int'(lock_log[a + 102]), 0);
        end else begin
            check_eq("p4_rise_count", rise_q.size(), 1);
        end
        check_eq("p4_to_sticky", int'(timeout), 1);

        // Resume: first rise only clears timeout, lock after the fifth rise
        clear_q();
        repeat (5) period_hl(50, 50);
        #1;
        check_eq("p4r_rise_count", rise_q.size(), 5);
        if (rise_q.size() > 0) begin
            r0 = rise_q[0];
            check_eq("p4r_to_at_rise", int'(to_log[r0]), 1);
            check_eq("p4r_to_cleared", int'(to_log[r0 + 1]), 0);
        end
        check_eq("p4r_pv_count", pv_val.size(), 4);
        foreach (pv_val[i]) check_eq("p4r_period", pv_val[i], 100);
        if (pv_lock.size() == 4) begin
            check_eq("p4r_lock_pv3", pv_lock[2], 0);
            check_eq("p4r_lock_pv4", pv_lock[3], 1);
        end

        // Glitch: low notch at +26, extra rising edge 30 cycles after the rise
        clear_q();
        hold(1'b1, 26);
        hold(1'b0, 4);
        hold(1'b1, 20);
        hold(1'b0, 50);
        period_hl(50, 50);
        #1;
        check_eq("p5_rise_count", rise_q.size(), 3);
        check_eq("p5_fall_count", fall_q.size(), 3);
        check_eq("p5_pv_count", pv_val.size(), 3);
        if (pv_val.size() == 3) begin
            check_eq("p5_period0", pv_val[0], 100);
            check_eq("p5_lock0", pv_lock[0], 1);
            check_eq("p5_glitch_period", pv_val[1], 30);
            check_eq("p5_lock_after_glitch", int'(lock_log[pv_cyc[1] + 1]), 0);
            check_eq("p5_next_period", pv_val[2], 70);
            check_eq("p5_lock_next", pv_lock[2], 0);
        end

        // Relock, then asynchronous reset with an edge inside the synchroniser
        repeat (4) period_hl(50, 50);
        #1;
        check_eq("p6_pre_rst_locked", int'(locked), 1);
        clk_in = 1'b1;
        @(posedge clk_100);
        #2;
        rst = 1'b1;
        #1;
        check_eq("p6_rst_rise",   int'(rise_strobe),  0);
        check_eq("p6_rst_fall",   int'(fall_strobe),  0);
        check_eq("p6_rst_period", int'(period),       0);
        check_eq("p6_rst_pv",     int'(period_valid), 0);
        check_eq("p6_rst_locked", int'(locked),       0);
        check_eq("p6_rst_to",     int'(timeout),      0);
        clear_q();
        clk_in = 1'b0;
        repeat (4) @(negedge clk_100);
        rst = 1'b0;
        hold(1'b0, 10);
        check_eq("p6_no_flushed_rise", rise_q.size(), 0);
        repeat (4) period_hl(50, 50);
        hold(1'b1, 10);
        #1;
        check_eq("p6_rise_count", rise_q.size(), 5);
        check_eq("p6_pv_count", pv_val.size(), 4);
        foreach (pv_val[i]) check_eq("p6_period", pv_val[i], 100);
        if (pv_lock.size() == 4) begin
            check_eq("p6_lock_pv3", pv_lock[2], 0);
            check_eq("p6_lock_pv4", pv_lock[3], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
